trigger_in_module: RTL and testbench
====================================

# trigger_in_module

Trigger-input reader for the NIRS board. It reads external trigger lines through a 74HC165-type parallel-in/serial-out shift register chain. Each scan latches the parallel inputs with SH/LD, shifts them in MSB first, and publishes the word and its rising-edge mask with a one-cycle valid strobe. It is the receive-side counterpart of the 74HC595 trigger output path. It sits beside it under the acquisition controller.

## Interface
Parameters:
- CLK_DIV, 4: i_clk cycles per SCK half-period and per LOAD/SETUP phase; legal range 3..255.
- DATA_LEN, 8: number of trigger bits; multiple of 8 (cascaded chips), 8..32.
- POLL_PERIOD, 1000: idle cycles between automatic scans; legal range 1..2^20.

Ports:
- i_clk  in  1  sole clock
- i_rst  in  1  reset, asynchronous, active-high
- i_scan_en  in  1  level; enables periodic polling
- i_read_req  in  1  single-cycle pulse; requests an immediate scan
- i_tri_in_qh  in  1  serial data from the last chip's QH
- o_tri_in_ld_n  out  1  SH/LD, active low
- o_tri_in_sck  out  1  shift clock
- o_tri_in_inh  out  1  clock inhibit, active high
- o_trigger_in_data  out  DATA_LEN  last scanned word; bit DATA_LEN-1 is the first bit shifted
- o_trigger_in_edge  out  DATA_LEN  new & ~previous, from the last scan
- o_trigger_in_valid  out  1  one-cycle strobe when data/edge update
- o_busy  out  1  high in every state except IDLE

One clock; reset is asynchronous and active-high.

## Operation
- States: IDLE, LOAD, SETUP, SHIFT, DONE.
- IDLE: o_tri_in_ld_n=1, o_tri_in_sck=0, o_tri_in_inh=1. Start condition is i_read_req, or the poll counter reaching POLL_PERIOD-1 while i_scan_en=1.
  - A simultaneous request and poll tick produce one scan.
  - The poll counter counts only in IDLE while i_scan_en=1.
  - The counter clears on start and whenever i_scan_en=0.
- LOAD: o_tri_in_ld_n=0 for CLK_DIV cycles. o_tri_in_inh stays 1.
- SETUP: o_tri_in_ld_n=1, o_tri_in_inh=0, o_tri_in_sck=0 for CLK_DIV cycles.
- SHIFT: DATA_LEN bit periods.
  - Each bit period is SCK low for CLK_DIV cycles, then SCK high for CLK_DIV cycles.
  - The synchronized QH is sampled on the last low cycle and shifted into the shift register LSB; the first sample ends up in the MSB.
  - After the high phase of the final bit, the FSM goes to DONE. The final SCK rise is harmless.
- DONE: one cycle.
  - o_trigger_in_data is loaded from the shift register.
  - o_trigger_in_edge = shift & ~o_trigger_in_data(old).
  - o_trigger_in_valid=1.
  - Next state is IDLE.
- i_tri_in_qh passes through a 2-flop synchronizer. CLK_DIV>=3 guarantees the sampled value is settled.
- i_read_req arriving while o_busy=1 is ignored, not queued.
- o_trigger_in_data and o_trigger_in_edge hold between strobes.
- Reset values: ld_n=1, sck=0, inh=1, data=0, edge=0, valid=0, busy=0, state=IDLE, counters=0, synchronizer=0.
- Reset mid-scan aborts immediately. The partial word is discarded, and the previous-word reference becomes 0.
- Widths:
  - Phase counter: $clog2(CLK_DIV+1).
  - Bit counter: $clog2(DATA_LEN+1).
  - Poll counter: 20 bits.
  - No counter may wrap inside a phase.

## Timing
- Request sampled in cycle t: LOAD occupies t+1..t+CLK_DIV, SETUP the next CLK_DIV cycles, SHIFT the next 2·CLK_DIV·DATA_LEN cycles.
- DONE/valid falls in cycle t+2·CLK_DIV·(DATA_LEN+1)+1. With defaults that is t+73.
- IDLE resumes the cycle after DONE. Auto-scan start-to-start spacing is POLL_PERIOD+2·CLK_DIV·(DATA_LEN+1)+1. With defaults that is 1073.
- All outputs are registered; no combinational path from inputs to outputs.
- SCK frequency is i_clk/(2·CLK_DIV).

## Structure
- Shared package trigger_pkg holds:
  - the state encoding localparams (IDLE..DONE);
  - the default CLK_DIV and DATA_LEN;
  - the trigger bit index constants, shared with the output path.
- Sub-module hc165_drive is the shift engine:
  - inputs: start, len;
  - outputs: ld_n/sck/inh, data, finish pulse, plus the synchronizer.
- trigger_in_module keeps the poll counter, request arbitration, edge detect and output registers.

## Test plan
- Reset: assert i_rst mid-cycle. All outputs take their reset values asynchronously: ld_n=1, sck=0, inh=1, data=0, valid=0.
- Single read: the chip model holds 0xA5; pulse i_read_req at t. Required: valid only at t+73, data=0xA5, edge=0xA5, and exactly 8 SCK rising edges.
- Edge detect: after the previous scan, the model holds 0xF0; read again. Required: data=0xF0, edge=0x50.
- Polling: POLL_PERIOD=100, i_scan_en=1 for 600 cycles. Required: valid strobes spaced exactly 173 cycles apart, and none after i_scan_en drops.
- Collisions: i_read_req coincident with a poll tick gives one scan. i_read_req during SHIFT is ignored, so there is no second strobe.
- Abort: i_rst during bit 4 of SHIFT, model holding 0x3C, then a new request. Required: no strobe from the aborted scan; the next strobe has data=0x3C and edge=0x3C.

Source files
------------

// File: rtl/trigger_pkg.sv
// Shared definitions for the trigger input/output paths: scan FSM encoding,
// default geometry and the trigger bit assignments.
package trigger_pkg;

    // Scan sequencer states
    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StLoad  = 3'd1,
        StSetup = 3'd2,
        StShift = 3'd3,
        StDone  = 3'd4
    } trig_state_e;

    localparam int unsigned DefClkDiv     = 4;
    localparam int unsigned DefDataLen    = 8;
    localparam int unsigned DefPollPeriod = 1000;

    // Trigger bit positions, identical on the input and output chains
    localparam int unsigned TrigIdxStart = 0;
    localparam int unsigned TrigIdxStop  = 1;
    localparam int unsigned TrigIdxMark  = 2;
    localparam int unsigned TrigIdxStimA = 3;
    localparam int unsigned TrigIdxStimB = 4;
    localparam int unsigned TrigIdxSync  = 5;
    localparam int unsigned TrigIdxAux0  = 6;
    localparam int unsigned TrigIdxAux1  = 7;

endpackage

// File: rtl/hc165_drive.sv
// Shift engine for a 74HC165 chain: latches the parallel inputs, clocks the
// chain out MSB first and pulses o_finish on the last cycle of the last bit.
module hc165_drive
    import trigger_pkg::*;
#(
    parameter int unsigned CLK_DIV  = DefClkDiv,
    parameter int unsigned DATA_LEN = DefDataLen
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic                              i_start,
    input  logic [$clog2(DATA_LEN + 1) - 1:0] i_len,
    input  logic                              i_qh,
    output logic                              o_ld_n,
    output logic                              o_sck,
    output logic                              o_inh,
    output logic [DATA_LEN - 1:0]             o_data,
    output logic                              o_finish,
    output logic                              o_busy
);

    localparam int unsigned CntW = $clog2(CLK_DIV + 1);
    localparam int unsigned BitW = $clog2(DATA_LEN + 1);
    localparam logic [CntW - 1:0] DivLast    = CntW'(CLK_DIV - 1);
    localparam logic [CntW - 1:0] DivPreLast = CntW'(CLK_DIV - 2);

    trig_state_e           state_q;
    logic [CntW - 1:0]     cnt_q;
    logic [BitW - 1:0]     bit_q;
    logic [DATA_LEN - 1:0] shift_q;
    logic                  qh_meta_q;
    logic                  qh_sync_q;
    logic                  ld_n_q;
    logic                  sck_q;
    logic                  inh_q;
    logic                  finish_q;
    logic                  busy_q;

    logic phase_end;
    logic last_bit;

    assign phase_end = (cnt_q == DivLast);
    assign last_bit  = (bit_q == (i_len - BitW'(1)));

    assign o_ld_n   = ld_n_q;
    assign o_sck    = sck_q;
    assign o_inh    = inh_q;
    assign o_data   = shift_q;
    assign o_finish = finish_q;
    assign o_busy   = busy_q;

    // Two-flop synchronizer on the serial data line
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            qh_meta_q <= 1'b0;
            qh_sync_q <= 1'b0;
        end else begin
            qh_meta_q <= i_qh;
            qh_sync_q <= qh_meta_q;
        end
    end

    // Scan sequencer with registered chip controls
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            ld_n_q   <= 1'b1;
            sck_q    <= 1'b0;
            inh_q    <= 1'b1;
            finish_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            finish_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (i_start) begin
                        state_q <= StLoad;
                        ld_n_q  <= 1'b0;
                        cnt_q   <= '0;
                        shift_q <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                StLoad: begin
                    if (phase_end) begin
                        state_q <= StSetup;
                        ld_n_q  <= 1'b1;
                        inh_q   <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StSetup: begin
                    if (phase_end) begin
                        state_q <= StShift;
                        cnt_q   <= '0;
                        bit_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StShift: begin
                    if (!sck_q) begin
                        // Sample on the last low cycle, just before SCK rises
                        if (phase_end) begin
                            shift_q <= {shift_q[DATA_LEN - 2:0], qh_sync_q};
                            sck_q   <= 1'b1;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + CntW'(1);
                        end
                    end else begin
                        // Lands finish on the final high cycle so the word publishes in DONE
                        if (last_bit && (cnt_q == DivPreLast)) begin
                            finish_q <= 1'b1;
                        end
                        if (phase_end) begin
                            sck_q <= 1'b0;
                            cnt_q <= '0;
                            if (last_bit) begin
                                state_q <= StDone;
                                inh_q   <= 1'b1;
                            end else begin
                                bit_q <= bit_q + BitW'(1);
                            end
                        end else begin
                            cnt_q <= cnt_q + CntW'(1);
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    ld_n_q  <= 1'b1;
                    sck_q   <= 1'b0;
                    inh_q   <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/trigger_in_module.sv
// Trigger input reader: schedules scans of the 74HC165 chain (on request or
// periodic poll) and publishes the word plus its rising-edge mask.
module trigger_in_module
    import trigger_pkg::*;
#(
    parameter int unsigned CLK_DIV     = DefClkDiv,
    parameter int unsigned DATA_LEN    = DefDataLen,
    parameter int unsigned POLL_PERIOD = DefPollPeriod
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_scan_en,
    input  logic                  i_read_req,
    input  logic                  i_tri_in_qh,
    output logic                  o_tri_in_ld_n,
    output logic                  o_tri_in_sck,
    output logic                  o_tri_in_inh,
    output logic [DATA_LEN - 1:0] o_trigger_in_data,
    output logic [DATA_LEN - 1:0] o_trigger_in_edge,
    output logic                  o_trigger_in_valid,
    output logic                  o_busy
);

    localparam int unsigned BitW = $clog2(DATA_LEN + 1);
    localparam logic [BitW - 1:0] LenBits  = BitW'(DATA_LEN);
    localparam logic [19:0]       PollLast = 20'(POLL_PERIOD - 1);

    logic                  busy;
    logic                  finish;
    logic [DATA_LEN - 1:0] shift_word;
    logic [19:0]           poll_q;
    logic                  poll_tick;
    logic                  start;
    logic [DATA_LEN - 1:0] data_q;
    logic [DATA_LEN - 1:0] edge_q;
    logic                  valid_q;

    // A request and a poll tick in the same cycle collapse into one scan;
    // requests while busy are dropped rather than queued
    assign poll_tick = i_scan_en && (poll_q == PollLast);
    assign start     = !busy && (i_read_req || poll_tick);

    assign o_trigger_in_data  = data_q;
    assign o_trigger_in_edge  = edge_q;
    assign o_trigger_in_valid = valid_q;
    assign o_busy             = busy;

    hc165_drive #(
        .CLK_DIV  (CLK_DIV),
        .DATA_LEN (DATA_LEN)
    ) u_drive (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_start  (start),
        .i_len    (LenBits),
        .i_qh     (i_tri_in_qh),
        .o_ld_n   (o_tri_in_ld_n),
        .o_sck    (o_tri_in_sck),
        .o_inh    (o_tri_in_inh),
        .o_data   (shift_word),
        .o_finish (finish),
        .o_busy   (busy)
    );

    // Poll counter: runs only while idle with polling enabled
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            poll_q <= '0;
        end else if (!i_scan_en || start) begin
            poll_q <= '0;
        end else if (!busy) begin
            poll_q <= poll_q + 20'd1;
        end
    end

    // Publish word and rising-edge mask against the previously published word
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            data_q  <= '0;
            edge_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= finish;
            if (finish) begin
                data_q <= shift_word;
                edge_q <= shift_word & ~data_q;
            end
        end
    end

endmodule

// File: tb/tb_trigger_in_module.sv
// Scoreboard bench for trigger_in_module with a behavioural 74HC165 model.
module tb_trigger_in_module;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scan_en = 1'b0;
    logic       read_req = 1'b0;
    logic       qh;
    logic       ld_n;
    logic       sck;
    logic       inh;
    logic [7:0] data;
    logic [7:0] edge_mask;
    logic       valid;
    logic       busy;

    trigger_in_module #(
        .CLK_DIV     (4),
        .DATA_LEN    (8),
        .POLL_PERIOD (100)
    ) dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_scan_en          (scan_en),
        .i_read_req         (read_req),
        .i_tri_in_qh        (qh),
        .o_tri_in_ld_n      (ld_n),
        .o_tri_in_sck       (sck),
        .o_tri_in_inh       (inh),
        .o_trigger_in_data  (data),
        .o_trigger_in_edge  (edge_mask),
        .o_trigger_in_valid (valid),
        .o_busy             (busy)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    typedef struct {
        logic [7:0]  data;
        logic [7:0]  edg;
        int unsigned cyc;
    } exp_t;
    exp_t sb[$];

    // 74HC165 model: parallel load while SH/LD low, shift toward QH on SCK rise
    logic [7:0]  par = 8'h00;
    logic [7:0]  chip = 8'h00;
    logic        sck_prev = 1'b0;
    int unsigned sck_rises = 0;
    assign qh = chip[7];

    always @(negedge clk) begin
        sck_prev <= sck;
        if (!ld_n) begin
            chip <= par;
        end else if (sck && !sck_prev && !inh) begin
            chip      <= {chip[6:0], 1'b0};
            sck_rises <= sck_rises + 1;
        end
    end

    // Monitor: every strobe must match the head of the scoreboard
    int unsigned strobes = 0;
    always @(negedge clk) begin
        exp_t e;
        if (valid) begin
            strobes <= strobes + 1;
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_strobe: valid=1 at cycle %0d, required 0", cyc);
            end else begin
                e = sb.pop_front();
                check("strobe_data", data, e.data);
                check("strobe_edge", edge_mask, e.edg);
                check("strobe_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic pulse_read(input bit expect_scan, input logic [7:0] d, input logic [7:0] e);
        @(negedge clk);
        read_req = 1'b1;
        if (expect_scan) sb.push_back('{data: d, edg: e, cyc: cyc + 73});
        @(negedge clk);
        read_req = 1'b0;
    endtask

    int unsigned t0;
    int unsigned rise_base;

    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        check("rst_ld_n", ld_n, 1);
        check("rst_sck", sck, 0);
        check("rst_inh", inh, 1);
        check("rst_data", data, 0);
        check("rst_edge", edge_mask, 0);
        check("rst_valid", valid, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Single read of 0xA5 with phase checks
        par = 8'hA5;
        rise_base = sck_rises;
        @(negedge clk);
        t0 = cyc;
        read_req = 1'b1;
        sb.push_back('{data: 8'hA5, edg: 8'hA5, cyc: t0 + 73});
        @(negedge clk);
        read_req = 1'b0;
        check("load_busy", busy, 1);
        check("load_ld_n", ld_n, 0);
        check("load_inh", inh, 1);
        repeat (4) @(negedge clk);
        check("setup_ld_n", ld_n, 1);
        check("setup_inh", inh, 0);
        check("setup_sck", sck, 0);
        repeat (8) @(negedge clk);
        check("shift_sck_high", sck, 1);
        repeat (61) @(negedge clk);
        check("idle_busy", busy, 0);
        check("sck_rise_count", sck_rises - rise_base, 8);
        check("hold_data_a5", data, 8'hA5);

        // Edge detect against previous word
        par = 8'hF0;
        pulse_read(1'b1, 8'hF0, 8'h50);
        repeat (80) @(negedge clk);

        // Request during SHIFT is dropped
        par = 8'h0F;
        pulse_read(1'b1, 8'h0F, 8'h0F);
        repeat (29) @(negedge clk);
        read_req = 1'b1;
        @(negedge clk);
        read_req = 1'b0;
        repeat (60) @(negedge clk);
        check("strobes_after_ignored_req", strobes, 3);

        // Polling, with a request landing on the first poll tick
        par = 8'h33;
        @(negedge clk);
        scan_en = 1'b1;
        repeat (99) @(negedge clk);
        read_req = 1'b1;
        sb.push_back('{data: 8'h33, edg: 8'h30, cyc: cyc + 73});
        sb.push_back('{data: 8'h33, edg: 8'h00, cyc: cyc + 246});
        sb.push_back('{data: 8'h33, edg: 8'h00, cyc: cyc + 419});
        @(negedge clk);
        read_req = 1'b0;
        repeat (500) @(negedge clk);
        scan_en = 1'b0;
        repeat (300) @(negedge clk);
        check("strobes_after_polling", strobes, 6);
        check("hold_edge_zero", edge_mask, 8'h00);

        // Reset during bit 4 of SHIFT, then a fresh read
        par = 8'h3C;
        pulse_read(1'b0, 8'h00, 8'h00);
        repeat (43) @(negedge clk);
        check("pre_abort_inh", inh, 0);
        #2;
        rst = 1'b1;
        #1;
        check("abort_ld_n", ld_n, 1);
        check("abort_sck", sck, 0);
        check("abort_inh", inh, 1);
        check("abort_data", data, 0);
        check("abort_edge", edge_mask, 0);
        check("abort_valid", valid, 0);
        check("abort_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        pulse_read(1'b1, 8'h3C, 8'h3C);
        repeat (80) @(negedge clk);

        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        check("total_strobes", strobes, 7);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
